// File: rtl/dpb_port_arbiter.sv
// Round-robin arbiter sharing one Gowin DPB port between two requesters.
// Registers the winning command onto the port and routes read data back by tag.
module dpb_port_arbiter #(
    parameter logic       READ_MODE = 1'b0,
    parameter logic [2:0] BLK_SEL   = 3'b000,
    parameter int         AW        = 14,
    parameter int         DW        = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WRE0,
    input  logic          WRE1,
    input  logic [AW-1:0] AD0,
    input  logic [AW-1:0] AD1,
    input  logic [DW-1:0] DI0,
    input  logic [DW-1:0] DI1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA,
    output logic          CE,
    output logic          OCE,
    output logic          WRE,
    output logic [AW-1:0] AD,
    output logic [DW-1:0] DI,
    output logic [2:0]    BLKSEL,
    input  logic [DW-1:0] DO
);

    // Tag pipeline depth covers the command register plus the DPB output latency.
    localparam int L = (READ_MODE == 1'b1) ? 3 : 2;

    logic         pri;
    logic         rd_push;
    logic [L-1:0] vld_pipe;
    logic [L-1:0] id_pipe;

    assign GNT0    = REQ0 & (~REQ1 | ~pri);
    assign GNT1    = REQ1 & (~REQ0 | pri);
    assign rd_push = (GNT0 & ~WRE0) | (GNT1 & ~WRE1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pri <= 1'b0;
        end else if (GNT0) begin
            pri <= 1'b1;
        end else if (GNT1) begin
            pri <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CE  <= 1'b0;
            WRE <= 1'b0;
            AD  <= '0;
            DI  <= '0;
        end else if (GNT0) begin
            CE  <= 1'b1;
            WRE <= WRE0;
            AD  <= AD0;
            DI  <= DI0;
        end else if (GNT1) begin
            CE  <= 1'b1;
            WRE <= WRE1;
            AD  <= AD1;
            DI  <= DI1;
        end else begin
            CE  <= 1'b0;
            WRE <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[L-2:0], rd_push};
            id_pipe  <= {id_pipe[L-2:0], GNT1};
        end
    end

    assign RVALID0 = vld_pipe[L-1] & ~id_pipe[L-1];
    assign RVALID1 = vld_pipe[L-1] & id_pipe[L-1];
    assign RDATA   = DO;
    assign OCE     = 1'b1;
    assign BLKSEL  = BLK_SEL;

endmodule

// File: tb/tb_dpb_port_arbiter.sv
// Bench for dpb_port_arbiter: a bypass and a pipelined instance share one
// stimulus stream, each backed by its own DPB model; reads are scoreboarded.
module tb_dpb_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, wre0 = 1'b0, wre1 = 1'b0;
    logic [AW-1:0] ad0 = '0, ad1 = '0;
    logic [DW-1:0] di0 = '0, di1 = '0;

    logic [1:0]    gnt0, gnt1, rv0, rv1, ce, oce, wre_o;
    logic [AW-1:0] ad_o [2];
    logic [DW-1:0] di_o [2];
    logic [DW-1:0] rdata [2];
    logic [2:0]    bsel [2];
    logic [DW-1:0] do0, do1, dreg0, dreg1;

    logic [DW-1:0] mem0 [0:(1<<AW)-1];
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    exp_t q [2][$];
    exp_t mon_e;
    int   cycle = 0;
    int   total = 0;
    int   passed = 0;

    // Model state: priority pointer and the command expected on the port.
    logic          pri_m = 1'b0;
    logic          e_ce = 1'b0, e_wre = 1'b0;
    logic [AW-1:0] e_ad = '0;
    logic [DW-1:0] e_di = '0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    dpb_port_arbiter #(.READ_MODE(1'b0), .BLK_SEL(3'b000), .AW(AW), .DW(DW)) u_byp (
        .CLK(CLK), .RESET(RESET),
        .REQ0(req0), .REQ1(req1), .WRE0(wre0), .WRE1(wre1),
        .AD0(ad0), .AD1(ad1), .DI0(di0), .DI1(di1),
        .GNT0(gnt0[0]), .GNT1(gnt1[0]), .RVALID0(rv0[0]), .RVALID1(rv1[0]),
        .RDATA(rdata[0]), .CE(ce[0]), .OCE(oce[0]), .WRE(wre_o[0]),
        .AD(ad_o[0]), .DI(di_o[0]), .BLKSEL(bsel[0]), .DO(do0)
    );

    dpb_port_arbiter #(.READ_MODE(1'b1), .BLK_SEL(3'b101), .AW(AW), .DW(DW)) u_pip (
        .CLK(CLK), .RESET(RESET),
        .REQ0(req0), .REQ1(req1), .WRE0(wre0), .WRE1(wre1),
        .AD0(ad0), .AD1(ad1), .DI0(di0), .DI1(di1),
        .GNT0(gnt0[1]), .GNT1(gnt1[1]), .RVALID0(rv0[1]), .RVALID1(rv1[1]),
        .RDATA(rdata[1]), .CE(ce[1]), .OCE(oce[1]), .WRE(wre_o[1]),
        .AD(ad_o[1]), .DI(di_o[1]), .BLKSEL(bsel[1]), .DO(do1)
    );

    // DPB models: bypass returns data the cycle after CE, pipeline adds an output register.
    always @(posedge CLK) begin
        if (ce[0]) begin
            if (wre_o[0]) mem0[ad_o[0]] <= di_o[0];
            else          dreg0 <= mem0[ad_o[0]];
        end
        if (ce[1]) begin
            if (wre_o[1]) mem1[ad_o[1]] <= di_o[1];
            else          dreg1 <= mem1[ad_o[1]];
        end
        do1 <= dreg1;
    end
    assign do0 = dreg0;

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s[dut%0d] cyc %0d: observed %0h expected %0h", tag, m, cycle, obs, exp);
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            for (int m = 0; m < 2; m++) begin
                if (rv0[m] | rv1[m]) begin
                    if (q[m].size() == 0) begin
                        chk("rvalid_unexpected", m, {30'd0, rv1[m], rv0[m]}, 32'd0);
                    end else begin
                        mon_e = q[m].pop_front();
                        chk("rvalid_cycle", m, cycle, mon_e.due);
                        chk("rvalid_id", m, {30'd0, rv1[m], rv0[m]}, mon_e.id ? 32'd2 : 32'd1);
                        chk("rdata", m, {16'd0, rdata[m]}, {16'd0, mon_e.data});
                    end
                end else if (q[m].size() > 0 && q[m][0].due <= cycle) begin
                    mon_e = q[m].pop_front();
                    chk("rvalid_missing", m, {30'd0, rv1[m], rv0[m]}, mon_e.id ? 32'd2 : 32'd1);
                end
            end
        end
    end

    // One cycle: drive just after posedge, check at negedge, advance the model.
    task automatic cyc(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic eg0, eg1, sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        req0 = r0; wre0 = w0; ad0 = a0; di0 = d0;
        req1 = r1; wre1 = w1; ad1 = a1; di1 = d1;
        @(negedge CLK);
        eg0 = r0 & (~r1 | ~pri_m);
        eg1 = r1 & (~r0 | pri_m);
        for (int m = 0; m < 2; m++) begin
            chk("ce", m, {31'd0, ce[m]}, {31'd0, e_ce});
            chk("wre", m, {31'd0, wre_o[m]}, {31'd0, e_wre});
            chk("ad", m, {18'd0, ad_o[m]}, {18'd0, e_ad});
            chk("di", m, {16'd0, di_o[m]}, {16'd0, e_di});
            chk("gnt", m, {30'd0, gnt1[m], gnt0[m]}, {30'd0, eg1, eg0});
        end
        if (eg0 | eg1) begin
            sw = eg0 ? w0 : w1;
            sa = eg0 ? a0 : a1;
            sd = eg0 ? d0 : d1;
            e_ce = 1'b1; e_wre = sw; e_ad = sa; e_di = sd;
            if (sw) begin
                ref_mem[sa] = sd;
            end else begin
                q[0].push_back('{id: eg1, data: ref_mem[sa], due: cycle + 2});
                q[1].push_back('{id: eg1, data: ref_mem[sa], due: cycle + 3});
            end
            pri_m = eg0;
        end else begin
            e_ce = 1'b0; e_wre = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        req0 = 0; req1 = 0; wre0 = 0; wre1 = 0;
        pri_m = 1'b0; e_ce = 0; e_wre = 0; e_ad = '0; e_di = '0;
        q[0].delete(); q[1].delete();
        @(negedge CLK);
        @(posedge CLK);
        #2;
        for (int m = 0; m < 2; m++) begin
            chk("rst_ce", m, {31'd0, ce[m]}, 32'd0);
            chk("rst_wre", m, {31'd0, wre_o[m]}, 32'd0);
            chk("rst_ad", m, {18'd0, ad_o[m]}, 32'd0);
            chk("rst_di", m, {16'd0, di_o[m]}, 32'd0);
            chk("rst_rvalid", m, {30'd0, rv1[m], rv0[m]}, 32'd0);
            chk("oce", m, {31'd0, oce[m]}, 32'd1);
        end
        chk("blksel", 0, {29'd0, bsel[0]}, 32'd0);
        chk("blksel", 1, {29'd0, bsel[1]}, 32'd5);
        RESET = 1'b0;
    endtask

    initial begin
        do_reset();
        // Preload via writes from both requesters.
        cyc(1, 1, 14'h0010, 16'hA5A5, 0, 0, '0, '0);
        cyc(1, 1, 14'h0003, 16'h1234, 0, 0, '0, '0);
        cyc(0, 0, '0, '0, 1, 1, 14'h0004, 16'h5678);
        cyc(1, 1, 14'h0000, 16'h0F0F, 0, 0, '0, '0);
        idle(2);
        // Single read.
        cyc(1, 0, 14'h0010, '0, 0, 0, '0, '0);
        idle(4);
        // Write has no response, then read it back.
        cyc(0, 0, '0, '0, 1, 1, 14'h0020, 16'hBEEF);
        idle(2);
        cyc(1, 0, 14'h0020, '0, 0, 0, '0, '0);
        idle(4);
        // Back-to-back reads from R1.
        cyc(0, 0, '0, '0, 1, 0, 14'h0003, '0);
        cyc(0, 0, '0, '0, 1, 0, 14'h0004, '0);
        idle(5);
        // Contention from reset.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 0, 14'h0003, '0, 1, 0, 14'h0004, '0);
        idle(5);
        // Reset while a read is in flight, then a contended read with PRI back at 0.
        cyc(0, 0, '0, '0, 1, 0, 14'h0010, '0);
        do_reset();
        idle(2);
        cyc(1, 0, 14'h0000, '0, 1, 0, 14'h0020, '0);
        cyc(0, 0, '0, '0, 1, 0, 14'h0020, '0);
        idle(10);
        for (int m = 0; m < 2; m++) chk("queue_drained", m, q[m].size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dpb_port_arbiter.md
# dpb_port_arbiter

Two-requester round-robin arbiter that shares one port (A or B) of a Gowin DPB block RAM between two independent clients. It registers the winning command onto the DPB port signals and tracks each read through the DPB output latency. It then returns read data to the requester that issued it with a single-cycle valid strobe. It sits between client logic and one DPB port; a second instance may own the other port.

## Interface
- READ_MODE, 1'b0, must match the DPB port's READ_MODE (0 = bypass, 1 = pipeline/output register)
- BLK_SEL, 3'b000, constant driven on BLKSEL; must match the DPB BLK_SEL for this port
- AW, 14, address width (DPB AD width)
- DW, 16, data width (DPB DI/DO width)

- CLK  in  1  port clock; same clock as the DPB port
- RESET  in  1  asynchronous, active-high reset
- REQ0 / REQ1  in  1  requester k has a command pending
- WRE0 / WRE1  in  1  1 = write, 0 = read
- AD0 / AD1  in  AW  address
- DI0 / DI1  in  DW  write data
- GNT0 / GNT1  out  1  combinational; command accepted this cycle
- RVALID0 / RVALID1  out  1  read data valid for requester k, one cycle per read
- RDATA  out  DW  shared read data; equals DO
- CE, OCE, WRE  out  1  to DPB port
- AD  out  AW  to DPB port
- DI  out  DW  to DPB port
- BLKSEL  out  3  to DPB port; constant BLK_SEL
- DO  in  DW  from DPB port

## Operation
- Handshake: a command transfers in a cycle where REQk=1 and GNTk=1. The requester holds REQk, WREk, ADk and DIk stable until it is granted. GNTk never asserts without REQk.
- Arbitration: at most one GNT per cycle.
  - Only one REQ high: that requester is granted.
  - Both REQ high: grant goes to the requester named by the priority pointer PRI.
  - After any grant to k, PRI moves to the other requester.
  - Reset value: PRI = 0 (R0 preferred).
- Command register, loaded every cycle:
  - CE = (a grant occurred).
  - WRE, AD, DI = the granted requester's values.
  - When nothing is granted: CE=0, WRE=0, AD and DI hold their previous values.
- OCE is driven 1 constantly. BLKSEL = BLK_SEL.
- Read tracking: each granted read pushes a tag {valid, id} into a shift pipeline of depth L.
  - L = 2 for READ_MODE=0; L = 3 for READ_MODE=1.
  - Writes push valid=0.
  - The pipeline output drives RVALIDid=1 for one cycle.
- Back-to-back reads are accepted every cycle, with no bubbles. Read data returns in issue order.
- Writes produce no response.
- A read and a write to the same address in consecutive grants follow DPB semantics; the arbiter does no hazard checking.

## Timing
- Read latency: a grant in cycle N puts the command on CE/AD in cycle N+1.
  - READ_MODE=0: RVALID in cycle N+2.
  - READ_MODE=1: RVALID in cycle N+3.
- Throughput: 1 command per cycle total. Under continuous contention each requester gets 1 command per 2 cycles.
- Reset values (asynchronous): CE=0, WRE=0, AD=0, DI=0, RVALID0=RVALID1=0, tag pipeline cleared, PRI=0. GNT is combinational and follows REQ/PRI immediately.
- Reset mid-operation: all in-flight reads are discarded and no RVALID fires for them. After RESET deasserts, the first grant is possible in the first clock, and the first RVALID comes no earlier than L cycles later.
- Simultaneous REQ0/REQ1 in the cycle after a grant to R0: R1 wins.
- RDATA is meaningful only while an RVALID is high.

## Test plan
- Single read, READ_MODE=0:
  - Stimulus: preload addr 0x0010=0xA5A5 via R0 write, then R0 read 0x0010 granted in cycle N.
  - Response: CE=1, WRE=0, AD=0x0010 in N+1; RVALID0=1, RDATA=0xA5A5 in N+2; RVALID1 stays 0.
- Contention:
  - Stimulus: REQ0 and REQ1 held high for 6 cycles, all reads, from reset.
  - Response: grants go R0,R1,R0,R1,R0,R1. RVALIDs return in the same order, each 2 cycles after its grant.
- Pipelined mode:
  - Stimulus: READ_MODE=1; R1 reads 0x0003 (holding 0x1234) and 0x0004 (holding 0x5678) back-to-back.
  - Response: RVALID1 in N+3 with 0x1234 and N+4 with 0x5678; no gap.
- Write has no response:
  - Stimulus: R1 writes 0x0020=0xBEEF.
  - Response: CE=1, WRE=1, DI=0xBEEF for one cycle; no RVALID. A later read of 0x0020 returns 0xBEEF.
- Reset mid-flight:
  - Stimulus: RESET pulses in cycle N+1 after a read grant in cycle N.
  - Response: no RVALID in N+2 or N+3, and all outputs are at reset values. After release, a read of 0x0000 completes normally with PRI=0.
- Idle:
  - Stimulus: no REQ for 10 cycles.
  - Response: CE=0 throughout; AD and DI hold their last values; no GNT.
